// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the pipelined MIPS core register file.
package pipeline_pkg;

    localparam logic TRAP_IRQ = 1'b0;
    localparam logic TRAP_EXC = 1'b1;

    localparam int unsigned REG_RA   = 31;
    localparam int unsigned REG_K0   = 26;
    localparam int unsigned LV_MAX_W = 64;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    // PC+4 with the top (supervisor) bit of a data_w-wide PC preserved; the
    // low field wraps without ever carrying into that bit.
    function automatic logic [LV_MAX_W-1:0] link_val(input logic [LV_MAX_W-1:0] pc,
                                                     input int unsigned         data_w);
        logic [LV_MAX_W-1:0] sup_mask;
        logic [LV_MAX_W-1:0] low_mask;
        sup_mask = LV_MAX_W'(1) << (data_w - 1);
        low_mask = sup_mask - LV_MAX_W'(1);
        return (pc & sup_mask) | ((pc + LV_MAX_W'(4)) & low_mask);
    endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// One read port: register 0 and the clear sweep read as zero, then optional
// same-cycle bypass of the architectural write, then the trap link write.
module regfile_read_mux
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic              i_run,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_arr_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_trap_en,
    input  logic [ADDR_W-1:0] i_trap_addr,
    input  logic [DATA_W-1:0] i_trap_data,
    output logic [DATA_W-1:0] o_rd_data
);

    always_comb begin
        o_rd_data = '0;
        if (i_run && (i_rd_addr != '0)) begin
            o_rd_data = i_arr_data;
            if (BYPASS != 0) begin
                if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
                    o_rd_data = i_wr_data;
                end else if (i_trap_en && (i_trap_addr == i_rd_addr)) begin
                    o_rd_data = i_trap_data;
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_regfile_mp.sv
// Multi-read-port register file for the ID stage: one architectural write
// port, one trap link-write port and a post-reset clear sweep.
module pipeline_regfile_mp
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned LINK_IRQ = REG_RA,
    parameter int unsigned LINK_EXC = REG_K0,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     trap_req,
    input  logic                     trap_kind,
    input  logic [DATA_W-1:0]        pc,
    output logic                     init_done,
    output logic                     trap_written,
    output logic                     trap_suppressed
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_init_done;
    logic              w_init_done_nxt;
    logic              w_sweep_en;
    logic              r_trap_written;
    logic              r_trap_suppressed;

    logic              w_run;
    logic              w_arch_we;
    logic              w_trap_ok;
    logic              w_trap_drop;
    logic [ADDR_W-1:0] w_link_dst;
    logic [DATA_W-1:0] w_link_val;

    // Sweep FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT;
            r_cnt       <= ADDR_W'(1);
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    // Sweep FSM next state: clear one register per cycle, register 0 is never stored.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_done_nxt = r_init_done;
        w_sweep_en      = 1'b0;
        case (r_state)
            INIT: begin
                w_sweep_en = 1'b1;
                w_cnt_nxt  = r_cnt + ADDR_W'(1);
                if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
                    w_state_nxt     = RUN;
                    w_init_done_nxt = 1'b1;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign w_run      = (r_state == RUN);
    assign w_arch_we  = w_run & wr_en & (wr_addr != '0);
    assign w_link_dst = (trap_kind == TRAP_EXC) ? ADDR_W'(LINK_EXC) : ADDR_W'(LINK_IRQ);
    assign w_link_val = DATA_W'(link_val(LV_MAX_W'(pc), DATA_W));

    // A colliding architectural write takes precedence over the link write.
    assign w_trap_ok   = w_run & trap_req & ~pc[DATA_W-1]
                       & ~(wr_en & (wr_addr == w_link_dst));
    assign w_trap_drop = w_run & trap_req & ~w_trap_ok;

    // Storage array has no reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_sweep_en) begin
            r_regs[r_cnt] <= '0;
        end
        if (w_arch_we) begin
            r_regs[wr_addr] <= wr_data;
        end
        if (w_trap_ok) begin
            r_regs[w_link_dst] <= w_link_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_trap_written    <= 1'b0;
            r_trap_suppressed <= 1'b0;
        end else begin
            r_trap_written    <= w_trap_ok;
            r_trap_suppressed <= w_trap_drop;
        end
    end

    assign init_done       = r_init_done;
    assign trap_written    = r_trap_written;
    assign trap_suppressed = r_trap_suppressed;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        regfile_read_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_read_mux (
            .i_run       (w_run),
            .i_rd_addr   (w_addr),
            .i_arr_data  (r_regs[w_addr]),
            .i_wr_en     (w_arch_we),
            .i_wr_addr   (wr_addr),
            .i_wr_data   (wr_data),
            .i_trap_en   (w_trap_ok),
            .i_trap_addr (w_link_dst),
            .i_trap_data (w_link_val),
            .o_rd_data   (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_pipeline_regfile_mp.sv
// Directed bench for pipeline_regfile_mp: sweep/reset sequences plus a
// table of RUN-mode read/write/trap vectors with hand-computed results.
module tb_pipeline_regfile_mp;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        trap_req;
    logic        trap_kind;
    logic [31:0] pc;
    logic        init_done;
    logic        trap_written;
    logic        trap_suppressed;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_regfile_mp dut (
        .clk             (clk),
        .reset           (reset),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .trap_req        (trap_req),
        .trap_kind       (trap_kind),
        .pc              (pc),
        .init_done       (init_done),
        .trap_written    (trap_written),
        .trap_suppressed (trap_suppressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        tr;
        logic        tk;
        logic [31:0] pcv;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        etw;
        logic        ets;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // we wa  wd            tr tk pc            ra0 ra1 e0            e1            tw ts
        vecs[0]  = '{1'b1, 5'd7,  32'h0000_1234, 1'b0, 1'b0, 32'h0,         5'd7,  5'd0,  32'h0000_1234, 32'h0,         1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 32'h0,         5'd7,  5'd5,  32'h0000_1234, 32'h0,         1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         5'd0,  5'd7,  32'h0,         32'h0000_1234, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 32'h0040_0010, 5'd31, 5'd7,  32'h0040_0014, 32'h0000_1234, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 32'h0,         5'd31, 5'd26, 32'h0040_0014, 32'h0,         1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 32'h7FFF_FFFC, 5'd26, 5'd31, 32'h0,         32'h0040_0014, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 32'h8000_0100, 5'd31, 5'd26, 32'h0040_0014, 32'h0,         1'b0, 1'b1};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 32'h0,         5'd31, 5'd26, 32'h0040_0014, 32'h0,         1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'd31, 32'h0000_AAAA, 1'b1, 1'b0, 32'h0000_0100, 5'd31, 5'd26, 32'h0000_AAAA, 32'h0,         1'b0, 1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 32'h0,         5'd31, 5'd7,  32'h0000_AAAA, 32'h0000_1234, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd9,  32'h0000_0099, 1'b1, 1'b1, 32'h0000_1000, 5'd9,  5'd26, 32'h0000_0099, 32'h0000_1004, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 32'h0,         5'd9,  5'd26, 32'h0000_0099, 32'h0000_1004, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 5'd26, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0020, 5'd26, 5'd31, 32'h0000_0005, 32'h0000_0024, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 32'h0,         5'd26, 5'd31, 32'h0000_0005, 32'h0000_0024, 1'b0, 1'b0};

        reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        trap_req = 1'b0; trap_kind = 1'b0; pc = '0;

        // First sweep: init_done rises exactly 31 cycles after reset drops.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
        chk("rst_trap_written", {31'b0, trap_written}, 32'd0);
        chk("rst_trap_suppressed", {31'b0, trap_suppressed}, 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sweep1_init_done_c%0d", k), {31'b0, init_done}, (k == 31) ? 32'd1 : 32'd0);
        end

        // Preload reg5 so the next sweep has something to clear.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_DEAD; rd_addr = {5'd0, 5'd5};
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        chk("preload_reg5", rd_data[31:0], 32'h0000_DEAD);

        // Second sweep with writes and traps held; reset again at sweep cycle 10.
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0055;
        trap_req = 1'b1; trap_kind = 1'b0; pc = 32'h0000_0100; rd_addr = {5'd3, 5'd5};
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sweep2_rd0_c%0d", k), rd_data[31:0], 32'h0);
            chk($sformatf("sweep2_trap_pulse_c%0d", k), {30'b0, trap_written, trap_suppressed}, 32'd0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sweep3_init_done_c%0d", k), {31'b0, init_done}, (k == 31) ? 32'd1 : 32'd0);
            chk($sformatf("sweep3_trap_pulse_c%0d", k), {30'b0, trap_written, trap_suppressed}, 32'd0);
        end
        wr_en = 1'b0; trap_req = 1'b0;
        #1;
        chk("post_sweep_reg5", rd_data[31:0], 32'h0);
        chk("post_init_write_reg3", rd_data[63:32], 32'h0);
        rd_addr = {5'd31, 5'd1};
        #1;
        chk("post_sweep_reg1", rd_data[31:0], 32'h0);
        chk("post_sweep_reg31", rd_data[63:32], 32'h0);

        // RUN-mode vector table: reads same cycle, pulses after the edge.
        for (int i = 0; i < NV; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            trap_req = vecs[i].tr; trap_kind = vecs[i].tk; pc = vecs[i].pcv;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("vec%0d_rd0", i), rd_data[31:0], vecs[i].e0);
            chk($sformatf("vec%0d_rd1", i), rd_data[63:32], vecs[i].e1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_trap_written", i), {31'b0, trap_written}, {31'b0, vecs[i].etw});
            chk($sformatf("vec%0d_trap_suppressed", i), {31'b0, trap_suppressed}, {31'b0, vecs[i].ets});
        end
        wr_en = 1'b0; trap_req = 1'b0;

        // Pulses last exactly one cycle.
        @(posedge clk); #1;
        chk("pulse_clear", {30'b0, trap_written, trap_suppressed}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
